mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous RAM (1-cycle read latency) between the CPU instruction-fetch
//   port (IF) and the load/store data port (DM). One access per cycle. Arbitrates conflicts,
//   bounds IF starvation and routes read data back to the requester that issued the read.
//   Sits between the core and the unified program/data BRAM inside Top.
// PARAMETERS
//   ADDR_W     10  word address width
//   DATA_W     32  data width; byte enables are DATA_W/8 bits wide
//   MAX_WAIT   3   consecutive IF denials tolerated before IF is forced through (fixed-priority mode)
// PORTS
//   sys_clk     in   1         system clock; all logic on its rising edge
//   sys_rst_n   in   1         reset, synchronous, active-low
//   if_req      in   1         IF read request; held with if_addr stable until if_gnt
//   if_addr     in   ADDR_W    IF word address
//   if_gnt      out  1         IF request accepted this cycle (combinational)
//   if_rvalid   out  1         IF read data valid
//   if_rdata    out  DATA_W    IF read data; meaningful only while if_rvalid=1
//   dm_req      in   1         DM request; held with payload stable until dm_gnt
//   dm_we       in   1         1 = write, 0 = read
//   dm_be       in   DATA_W/8  byte enables for writes
//   dm_addr     in   ADDR_W    DM word address
//   dm_wdata    in   DATA_W    DM write data
//   dm_gnt      out  1         DM request accepted this cycle (combinational)
//   dm_rvalid   out  1         DM read data valid (reads only)
//   dm_rdata    out  DATA_W    DM read data; meaningful only while dm_rvalid=1
//   mem_en      out  1         RAM access enable
//   mem_we      out  DATA_W/8  RAM byte write enables (0 for reads)
//   mem_addr    out  ADDR_W    RAM address
//   mem_wdata   out  DATA_W    RAM write data
//   mem_rdata   in   DATA_W    RAM read data, valid the cycle after a read access
// BEHAVIOUR
//   - Reset (sys_rst_n=0 at an edge): rvalid outputs, rd_owner, wait_cnt and rr_ptr cleared
//     (rr_ptr points to IF); gnt/mem_* outputs are 0 while sys_rst_n=0. An in-flight read is
//     dropped: no rvalid follows a grant issued in the cycle reset is sampled.
//   - Grant is combinational; at most one of if_gnt/dm_gnt per cycle. Granted request drives
//     mem_en=1 and mem_addr the same cycle; DM write: mem_we=dm_be, mem_wdata=dm_wdata; reads: mem_we=0.
//   - Only one requester: it is granted immediately (zero wait).
//   - Both requesting (fixed priority): DM wins; wait_cnt increments per denied IF cycle;
//     when wait_cnt==MAX_WAIT, IF wins and wait_cnt clears. wait_cnt clears on any IF grant
//     or any cycle with if_req=0; saturates at MAX_WAIT.
//   - Read latency: grant of a read in cycle N -> owner's rvalid=1 in cycle N+1 only,
//     rdata = mem_rdata in that cycle. rd_owner register records IF/DM/none for cycle N+1.
//   - Writes never raise rvalid. Back-to-back grants every cycle allowed; a write in N followed
//     by a read of the same address in N+1 returns the new data (RAM write-first).
//   - Idle cycle (no req): mem_en=0, mem_we=0, mem_addr/mem_wdata don't-care.
//   - Requester must not drop req before gnt; behaviour for a withdrawn request is undefined.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined: on conflict the winner alternates; rr_ptr flips to the
//     other requester after every contested grant; uncontested grants leave rr_ptr unchanged;
//     wait_cnt and MAX_WAIT unused (logic removed).
//   Not defined: fixed priority DM > IF with MAX_WAIT starvation guard as above.
// TESTING
//   1 Reset: hold sys_rst_n=0 with both reqs high -> all gnt/rvalid/mem_en/mem_we=0; release -> DM granted first.
//   2 IF only, if_addr=0x004, mem returns 0x00000013 -> if_gnt in N, if_rvalid=1 with
//     if_rdata=0x00000013 in N+1, dm_rvalid=0.
//   3 DM write addr 0x010 data 0xDEADBEEF be=4'b1111, then DM read 0x010 next cycle ->
//     mem_we=4'hF in N, dm_rvalid=1 with 0xDEADBEEF in N+2; no rvalid after write.
//   4 Both req continuously, MAX_WAIT=3, fixed priority -> grant pattern DM,DM,DM,IF,DM,DM,DM,IF.
//   5 Same stimulus with ARB_ROUND_ROBIN_EN -> DM,IF,DM,IF...; rvalid routed to matching port each cycle.
//   6 Read granted in N, sys_rst_n=0 sampled at end of N -> no rvalid in N+1; arbiter restarts cleanly.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous BRAM between the instruction-fetch (IF) and load/store (DM) ports.
// Default: DM-priority with an IF starvation guard. Define ARB_ROUND_ROBIN_EN for alternating arbitration.
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_be,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } rd_owner_t;

    logic      if_gnt_c;
    logic      dm_gnt_c;
    logic      if_prio;
    rd_owner_t rd_owner_reg;
    rd_owner_t rd_owner_next;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr_reg names the last contest winner (0 = IF), so the first contest after reset goes to DM.
    logic rr_ptr_reg;
    logic rr_ptr_next;

    assign if_prio = rr_ptr_reg;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (if_gnt_c && dm_req) begin
            rr_ptr_next = 1'b0;
        end else if (dm_gnt_c && if_req) begin
            rr_ptr_next = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rr_ptr_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    localparam int              CNT_W      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;

    // IF is forced through once it has been denied MAX_WAIT times in a row.
    assign if_prio = (wait_cnt_reg == WAIT_LIMIT);

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!if_req || if_gnt_c) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    always_comb begin
        if_gnt_c = 1'b0;
        dm_gnt_c = 1'b0;
        if (sys_rst_n) begin
            if (if_req && dm_req) begin
                if_gnt_c = if_prio;
                dm_gnt_c = !if_prio;
            end else begin
                if_gnt_c = if_req;
                dm_gnt_c = dm_req;
            end
        end
    end

    assign if_gnt    = if_gnt_c;
    assign dm_gnt    = dm_gnt_c;
    assign mem_en    = if_gnt_c || dm_gnt_c;
    assign mem_wdata = (dm_gnt_c && dm_we) ? dm_wdata : '0;

    always_comb begin
        mem_addr = '0;
        if (dm_gnt_c) begin
            mem_addr = dm_addr;
        end else if (if_gnt_c) begin
            mem_addr = if_addr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_byte_we
            assign mem_we[gi] = dm_gnt_c && dm_we && dm_be[gi];
        end
    endgenerate

    // The read owner is latched at grant so returning data follows the issuer, not the next winner.
    always_comb begin
        rd_owner_next = OWN_NONE;
        if (if_gnt_c) begin
            rd_owner_next = OWN_IF;
        end else if (dm_gnt_c && !dm_we) begin
            rd_owner_next = OWN_DM;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_owner_reg <= OWN_NONE;
        end else begin
            rd_owner_reg <= rd_owner_next;
        end
    end

    assign if_rvalid = (rd_owner_reg == OWN_IF);
    assign dm_rvalid = (rd_owner_reg == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random IF/DM traffic against a behavioural RAM,
// with expected grants and read data derived from an arbitration/memory reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 3;
    localparam int BE_W     = DATA_W / 8;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sys_rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [BE_W-1:0]   dm_be = '0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              dm_gnt, dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(sys_rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural write-first single-port RAM with one cycle of read latency.
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) begin
            ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_we);
            mem_rdata     <= merge(ram[mem_addr], mem_wdata, mem_we);
        end
    end

    // Reference model state: memory image, IF denial streak, last contest winner.
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    logic [DATA_W-1:0] if_q[$];
    logic [DATA_W-1:0] dm_q[$];
    int   if_denied_run = 0;
    bit   last_contest_if = 1'b1;
    logic rst_seen = 1'b0;

    bit                st_if = 0, st_dm = 0, st_if_req = 0, st_dm_req = 0, st_dm_we = 0;
    logic [ADDR_W-1:0] st_if_addr = '0, st_dm_addr = '0;
    logic [BE_W-1:0]   st_dm_be = '0;
    logic [DATA_W-1:0] st_dm_wdata = '0;
    bit                if_acc = 0, dm_acc = 0;

    always @(posedge clk) rst_seen <= sys_rst_n;

    // Model: retire last cycle's grant (or drop it if reset was sampled), then predict this cycle.
    always @(negedge clk) begin
        bit              exp_if, exp_dm;
        logic [BE_W-1:0] exp_we;
        if (!rst_seen) begin
            if_q.delete();
            dm_q.delete();
            if_denied_run   = 0;
            last_contest_if = 1'b1;
        end else begin
            if (st_if) if_q.push_back(ref_mem[st_if_addr]);
            if (st_dm) begin
                if (st_dm_we) ref_mem[st_dm_addr] = merge(ref_mem[st_dm_addr], st_dm_wdata, st_dm_be);
                else          dm_q.push_back(ref_mem[st_dm_addr]);
            end
            if (st_if_req && st_dm_req) last_contest_if = st_if;
            if (st_if_req && !st_if) if_denied_run++;
            else                     if_denied_run = 0;
        end

        exp_if = 1'b0;
        exp_dm = 1'b0;
        if (sys_rst_n) begin
            if (if_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_if = !last_contest_if;
`else
                exp_if = (if_denied_run >= MAX_WAIT);
`endif
                exp_dm = !exp_if;
            end else begin
                exp_if = if_req;
                exp_dm = dm_req;
            end
        end
        exp_we = (exp_dm && dm_we) ? dm_be : '0;

        checks++;
        if (if_gnt !== exp_if || dm_gnt !== exp_dm) begin
            failures++;
            $display("FAIL grant got if=%b dm=%b required if=%b dm=%b t=%0t", if_gnt, dm_gnt, exp_if, exp_dm, $time);
        end
        checks++;
        if (mem_en !== (exp_if || exp_dm) || mem_we !== exp_we) begin
            failures++;
            $display("FAIL mem_ctl got en=%b we=%h required en=%b we=%h t=%0t", mem_en, mem_we, exp_if || exp_dm, exp_we, $time);
        end
        if (exp_dm || exp_if || !sys_rst_n) begin
            logic [ADDR_W-1:0] exp_addr;
            exp_addr = exp_dm ? dm_addr : (exp_if ? if_addr : '0);
            checks++;
            if (mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL mem_addr got=%h required=%h t=%0t", mem_addr, exp_addr, $time);
            end
        end
        if (exp_dm && dm_we) begin
            checks++;
            if (mem_wdata !== dm_wdata) begin
                failures++;
                $display("FAIL mem_wdata got=%h required=%h t=%0t", mem_wdata, dm_wdata, $time);
            end
        end

        st_if = exp_if;           st_dm = exp_dm;
        st_if_req = if_req;       st_dm_req = dm_req;
        st_if_addr = if_addr;     st_dm_addr = dm_addr;
        st_dm_we = dm_we;         st_dm_be = dm_be;
        st_dm_wdata = dm_wdata;
        if_acc = if_gnt;          dm_acc = dm_gnt;
    end

    // Monitor: every rvalid must consume exactly the expected entry, no rvalid without one.
    always begin
        logic [DATA_W-1:0] exp_d;
        @(negedge clk);
        #2;
        if (if_q.size() > 0) begin
            exp_d = if_q.pop_front();
            checks++;
            if (if_rvalid !== 1'b1 || if_rdata !== exp_d) begin
                failures++;
                $display("FAIL if_read got rvalid=%b data=%h required rvalid=1 data=%h t=%0t", if_rvalid, if_rdata, exp_d, $time);
            end
        end else begin
            checks++;
            if (if_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL if_rvalid_spurious got=%b required=0 t=%0t", if_rvalid, $time);
            end
        end
        if (dm_q.size() > 0) begin
            exp_d = dm_q.pop_front();
            checks++;
            if (dm_rvalid !== 1'b1 || dm_rdata !== exp_d) begin
                failures++;
                $display("FAIL dm_read got rvalid=%b data=%h required rvalid=1 data=%h t=%0t", dm_rvalid, dm_rdata, exp_d, $time);
            end
        end else begin
            checks++;
            if (dm_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL dm_rvalid_spurious got=%b required=0 t=%0t", dm_rvalid, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_if);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (is_if ? if_gnt : dm_gnt) break;
            n++;
            if (n > 16) begin
                checks++;
                failures++;
                $display("FAIL gnt_timeout port=%s got=0 required=1", is_if ? "IF" : "DM");
                break;
            end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] v;
            v = DATA_W'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[4] = 32'h0000_0013;
        ref_mem[4] = 32'h0000_0013;

        // Reset held with both requesters active: model expects no grants, no rvalid.
        sys_rst_n = 1'b0;
        if_req = 1'b1; if_addr = 10'h001;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h002;
        repeat (3) tick();
        sys_rst_n = 1'b1;

        // Continuous contention straight out of reset: check the grant pattern.
        for (int k = 0; k < 8; k++) begin
            int got, req;
            bit ig, dg;
            @(negedge clk);
            ig = if_gnt;
            dg = dm_gnt;
            got = dg ? 1 : (ig ? 2 : 0);
`ifdef ARB_ROUND_ROBIN_EN
            req = (k % 2 == 0) ? 1 : 2;
`else
            req = (k % 4 == 3) ? 2 : 1;
`endif
            checks++;
            if (got != req) begin
                failures++;
                $display("FAIL grant_pattern k=%0d got=%0d required=%0d (1=DM 2=IF)", k, got, req);
            end
            tick();
            if (dg) dm_addr = ADDR_W'($urandom_range(0, 15));
            if (ig) if_addr = ADDR_W'($urandom_range(0, 15));
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();

        // IF-only fetch of a known word.
        if_req = 1'b1; if_addr = 10'h004;
        wait_gnt(1'b1);
        if_req = 1'b0;
        repeat (2) tick();

        // DM write followed immediately by a read of the same word.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h010; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        wait_gnt(1'b0);
        dm_we = 1'b0;
        wait_gnt(1'b0);
        dm_req = 1'b0;
        repeat (2) tick();

        // Reset sampled at the end of a read-grant cycle drops that read.
        if_req = 1'b1; if_addr = 10'h005;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_drop_setup got if_gnt=%b required=1", if_gnt);
        end
        #3;
        sys_rst_n = 1'b0;
        if_req = 1'b0;
        tick();
        @(negedge clk);
        #2;
        checks++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_drop got if_rvalid=%b dm_rvalid=%b required 0 0", if_rvalid, dm_rvalid);
        end
        tick();
        sys_rst_n = 1'b1;

        // Random traffic with a reset pulse in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500)      sys_rst_n = 1'b0;
            else if (c == 1503) sys_rst_n = 1'b1;
            if (!if_req || if_acc) begin
                if_req  = ($urandom_range(0, 99) < 65);
                if_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!dm_req || dm_acc) begin
                dm_req   = ($urandom_range(0, 99) < 65);
                dm_we    = 1'($urandom_range(0, 1));
                dm_be    = BE_W'($urandom);
                dm_addr  = ADDR_W'($urandom_range(0, 15));
                dm_wdata = DATA_W'($urandom);
            end
            tick();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
